// File: rtl/cle_pkg.sv
// Shared types and constants for the CLE key PAL sequencer.
// Holds the FSM state type, the decode-window constants and the idle bus bundle.
package cle_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SETUP,
        S_STROBE,
        S_WAIT,
        S_SAMPLE,
        S_DONE,
        S_ABORT
    } cle_seq_state_t;

    localparam logic CLE_BA13      = 1'b0;
    localparam logic CLE_BA12      = 1'b1;
    localparam logic CLE_BR_W_READ = 1'b1;

    typedef struct packed {
        logic       sser_n;
        logic       ba13;
        logic       ba12;
        logic [3:0] ba7_4;
        logic       br_w;
        logic       pal_clk;
    } cle_bus_t;

    localparam cle_bus_t CLE_BUS_IDLE = '{
        sser_n:  1'b1,
        ba13:    1'b0,
        ba12:    1'b0,
        ba7_4:   4'h0,
        br_w:    1'b1,
        pal_clk: 1'b0
    };

endpackage

// File: rtl/cle_step_timer.sv
// Settle-time down-counter used for the WAIT phase of each step.
// Ports: clk, rst_n, load_i/load_val_i (preset), en_i (count), expire_o (last cycle).
module cle_step_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic       expire_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded with the WAIT length; a value of 1 marks the final WAIT cycle.
    assign expire_o = (cnt_q <= 4'd1);

endmodule

// File: rtl/cle_key_sequencer.sv
// Sequences read cycles into the CLE key PAL window and assembles the SDRD bits.
// Ports: start/abort/seq_nib in, busy/done/aborted/result out, bus_req/bus_gnt, PAL bus.
module cle_key_sequencer #(
    parameter int NSTEPS = 16,
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [4*NSTEPS-1:0] seq_nib,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [NSTEPS-1:0]   result,
    output logic                bus_req,
    input  logic                bus_gnt,
    output logic                sser_n,
    output logic                ba13,
    output logic                ba12,
    output logic [3:0]          ba7_4,
    output logic                br_w,
    output logic                pal_clk,
    input  logic                sdrd
);

    import cle_pkg::*;

    localparam int SW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [SW-1:0] LAST = SW'(NSTEPS - 1);
    localparam logic [3:0] WAIT_LOAD = 4'(SETTLE - 1);

    cle_seq_state_t      state_q, state_d;
    logic [SW-1:0]       step_q, step_d;
    logic [4*NSTEPS-1:0] nib_q, nib_d;
    logic [NSTEPS-1:0]   result_q, result_d;
    cle_bus_t            bus_q, bus_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic                req_q, req_d;
    logic                lost;
    logic                expire;

    // Once granted, losing the grant is treated exactly like an abort.
    assign lost = abort || !bus_gnt;

    cle_step_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_q == S_STROBE),
        .load_val_i (WAIT_LOAD),
        .en_i       (state_q == S_WAIT),
        .expire_o   (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            nib_q     <= '0;
            result_q  <= '0;
            bus_q     <= CLE_BUS_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            nib_q     <= nib_d;
            result_q  <= result_d;
            bus_q     <= bus_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            req_q     <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_REQ;
            end
            S_REQ: begin
                if (abort) state_d = S_ABORT;
                else if (bus_gnt) state_d = S_SETUP;
            end
            S_SETUP: begin
                state_d = lost ? S_ABORT : S_STROBE;
            end
            S_STROBE: begin
                if (lost) state_d = S_ABORT;
                else state_d = (SETTLE == 1) ? S_SAMPLE : S_WAIT;
            end
            S_WAIT: begin
                if (lost) state_d = S_ABORT;
                else if (expire) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (lost) state_d = S_ABORT;
                else if (step_q == LAST) state_d = S_DONE;
                else state_d = S_SETUP;
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so every
    // bus line lines up with the state it belongs to and never glitches.
    always_comb begin
        nib_d     = nib_q;
        step_d    = step_q;
        result_d  = result_q;
        bus_d     = CLE_BUS_IDLE;
        req_d     = 1'b0;
        busy_d    = 1'b0;
        done_d    = (state_d == S_DONE);
        aborted_d = (state_d == S_ABORT);

        if ((state_q == S_IDLE) && start) begin
            nib_d    = seq_nib;
            step_d   = '0;
            result_d = '0;
        end

        // An abort in the sample cycle wins: that bit is not recorded.
        if ((state_q == S_SAMPLE) && (state_d != S_ABORT)) begin
            result_d[step_q] = sdrd;
            if (state_d == S_SETUP) step_d = step_q + 1'b1;
        end

        unique case (state_d)
            S_REQ: begin
                req_d  = 1'b1;
                busy_d = 1'b1;
            end
            S_SETUP, S_STROBE, S_WAIT, S_SAMPLE: begin
                req_d         = 1'b1;
                busy_d        = 1'b1;
                bus_d.sser_n  = 1'b0;
                bus_d.ba13    = CLE_BA13;
                bus_d.ba12    = CLE_BA12;
                bus_d.br_w    = CLE_BR_W_READ;
                bus_d.ba7_4   = nib_q[4*step_d +: 4];
                bus_d.pal_clk = (state_d == S_STROBE);
            end
            default: begin
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign result  = result_q;
    assign bus_req = req_q;
    assign sser_n  = bus_q.sser_n;
    assign ba13    = bus_q.ba13;
    assign ba12    = bus_q.ba12;
    assign ba7_4   = bus_q.ba7_4;
    assign br_w    = bus_q.br_w;
    assign pal_clk = bus_q.pal_clk;

endmodule

// File: tb/tb_cle_key_sequencer.sv
// Self-checking bench for cle_key_sequencer with a PAL model and arbiter driver.
// Two instances: default parameters and a short NSTEPS=4, SETTLE=1 variant.
module tb_cle_key_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort, bus_gnt, sdrd;
    logic [63:0] seq_nib;
    logic        busy, done, aborted, bus_req, sser_n, ba13, ba12, br_w, pal_clk;
    logic [15:0] result;
    logic [3:0]  ba7_4;

    logic        start4, abort4, bus_gnt4, sdrd4;
    logic [15:0] seq_nib4;
    logic        busy4, done4, aborted4, bus_req4, sser_n4, ba13_4, ba12_4, br_w4, pal_clk4;
    logic [3:0]  result4;
    logic [3:0]  ba_nib4;

    int total = 0;
    int bad = 0;

    cle_key_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .seq_nib(seq_nib), .busy(busy), .done(done), .aborted(aborted),
        .result(result), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .sser_n(sser_n), .ba13(ba13), .ba12(ba12), .ba7_4(ba7_4),
        .br_w(br_w), .pal_clk(pal_clk), .sdrd(sdrd)
    );

    cle_key_sequencer #(.NSTEPS(4), .SETTLE(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .seq_nib(seq_nib4), .busy(busy4), .done(done4), .aborted(aborted4),
        .result(result4), .bus_req(bus_req4), .bus_gnt(bus_gnt4),
        .sser_n(sser_n4), .ba13(ba13_4), .ba12(ba12_4), .ba7_4(ba_nib4),
        .br_w(br_w4), .pal_clk(pal_clk4), .sdrd(sdrd4)
    );

    // PAL model: answers parity of the strobed nibble; the bit is wrong
    // until SETTLE cycles after the strobe (SETTLE=2 here).
    logic pbit = 1'b0;
    int   pcnt = 0;
    always @(posedge clk) begin
        if (pal_clk) begin
            pbit <= ^ba7_4;
            pcnt <= 1;
        end else if (pcnt > 0) begin
            pcnt <= pcnt - 1;
        end
    end
    assign sdrd = (pcnt == 0) ? pbit : ~pbit;

    logic pbit4 = 1'b0;
    always @(posedge clk) if (pal_clk4) pbit4 <= ^ba_nib4;
    assign sdrd4 = pbit4;

    // Strobe monitor: records every strobed nibble and window violations.
    logic [3:0] prev_ba = 4'h0;
    int         stab_err = 0;
    logic [3:0] obs_q[$];
    always @(negedge clk) begin
        if (pal_clk) begin
            if (ba7_4 !== prev_ba || sser_n !== 1'b0 || ba12 !== 1'b1 ||
                ba13 !== 1'b0 || br_w !== 1'b1)
                stab_err++;
            obs_q.push_back(ba7_4);
        end
        prev_ba = ba7_4;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_res(input logic [63:0] n, input int cnt);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < cnt; k++) r[k] = ^n[4*k +: 4];
        return r;
    endfunction

    // kind: 0 normal, 1 abort dly cycles after step 'at' strobe,
    // 2 grant drop in step 'at' strobe, 3 reset in step 'at' strobe.
    task automatic run(input logic [63:0] nib, input int gd, input int kind,
                       input int at, input int dly);
        int cyc, pulses, acnt, base_q, base_e, nerr, ncyc, nexp;
        bit fin, rst_hit;
        base_q = obs_q.size();
        base_e = stab_err;
        @(negedge clk);
        start = 1'b1;
        seq_nib = nib;
        @(negedge clk);
        start = 1'b0;
        seq_nib = {$urandom, $urandom};
        chk("req_lat", {busy, bus_req}, 2'b11);
        cyc = 1;
        for (int i = 0; i < gd; i++) begin
            @(negedge clk);
            cyc++;
            chk("req_hold", {bus_req, pal_clk, sser_n}, 3'b101);
        end
        bus_gnt = 1'b1;
        pulses = 0;
        acnt = 0;
        fin = 1'b0;
        rst_hit = 1'b0;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            abort = 1'b0;
            if (done || aborted) begin
                fin = 1'b1;
            end else begin
                if (acnt > 0) begin
                    acnt--;
                    if (acnt == 0) abort = 1'b1;
                end
                if (pal_clk) begin
                    if (pulses == at) begin
                        if (kind == 1) acnt = dly;
                        if (kind == 2) bus_gnt = 1'b0;
                        if (kind == 3) begin
                            rst_n = 1'b0;
                            rst_hit = 1'b1;
                            fin = 1'b1;
                        end
                    end
                    pulses++;
                end
            end
        end
        chk("finished", fin, 1);
        if (rst_hit) begin
            @(negedge clk);
            chk("rst_bus", {busy, done, aborted, bus_req, sser_n, ba13, ba12,
                            ba7_4, br_w, pal_clk}, 13'b0000100000010);
            chk("rst_res", result, 0);
            rst_n = 1'b1;
            bus_gnt = 1'b0;
            repeat (4) begin
                @(negedge clk);
                chk("rst_quiet", {busy, done, aborted, bus_req}, 4'b0);
            end
        end else begin
            ncyc = (kind == 0) ? 66 + gd : 4 + gd + 4*at + ((kind == 1) ? dly : 0);
            nexp = (kind == 0) ? 16 : at;
            chk("end_lat", cyc, ncyc);
            chk("end_pulse", {done, aborted}, (kind == 0) ? 2'b10 : 2'b01);
            chk("end_bus", {busy, bus_req, sser_n, ba12, pal_clk}, 5'b00100);
            chk("result", result, exp_res(nib, nexp));
            chk("pulses", pulses, (kind == 0) ? 16 : at + 1);
            nerr = 0;
            for (int i = 0; i < pulses; i++) begin
                if (base_q + i >= obs_q.size()) nerr++;
                else if (obs_q[base_q + i] != nib[4*i +: 4]) nerr++;
            end
            chk("nibs", nerr, 0);
            chk("stable", stab_err - base_e, 0);
            bus_gnt = 1'b0;
            @(negedge clk);
            chk("idle", {busy, done, aborted, bus_req}, 4'b0);
        end
    endtask

    initial begin
        int cyc;
        logic [15:0] n4;
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        bus_gnt = 1'b0;
        seq_nib = '0;
        start4 = 1'b0;
        abort4 = 1'b0;
        bus_gnt4 = 1'b0;
        seq_nib4 = '0;
        repeat (3) @(negedge clk);
        chk("reset_bus", {busy, done, aborted, bus_req, sser_n, ba13, ba12,
                          ba7_4, br_w, pal_clk}, 13'b0000100000010);
        chk("reset_res", result, 0);
        chk("reset4", {busy4, done4, bus_req4, sser_n4, result4}, 8'b00010000);
        rst_n = 1'b1;

        run(64'h0123_4567_89AB_CDEF, 0, 0, 0, 0);
        chk("r6996", result, 16'h6996);
        run(64'h0123_4567_89AB_CDEF, 10, 0, 0, 0);
        run({$urandom, $urandom}, 2, 1, 5, 1);
        run({$urandom, $urandom}, 0, 2, 9, 0);
        run({$urandom, $urandom}, 1, 1, 7, 2);
        run({$urandom, $urandom}, 0, 3, 3, 0);
        run(64'h0123_4567_89AB_CDEF, 0, 0, 0, 0);
        repeat (8) begin
            k = $urandom_range(0, 2);
            run({$urandom, $urandom}, $urandom_range(0, 4), k,
                $urandom_range(0, 15), $urandom_range(1, 2));
        end

        n4 = 16'($urandom);
        @(negedge clk);
        start4 = 1'b1;
        seq_nib4 = n4;
        @(negedge clk);
        start4 = 1'b0;
        seq_nib4 = 16'($urandom);
        chk("d4_req", bus_req4, 1);
        bus_gnt4 = 1'b1;
        cyc = 1;
        while (!done4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start4 = (cyc == 6);
        end
        chk("d4_lat", cyc, 14);
        chk("d4_res", result4, exp_res({48'h0, n4}, 4));
        chk("d4_busy", busy4, 0);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("d4_ign", {busy4, bus_req4}, 2'b00);
        n4 = 16'($urandom);
        seq_nib4 = n4;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("d4_acc", {busy4, bus_req4}, 2'b11);
        cyc = 1;
        while (!done4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("d4_lat2", cyc, 14);
        chk("d4_res2", result4, exp_res({48'h0, n4}, 4));
        bus_gnt4 = 1'b0;
        @(negedge clk);
        chk("d4_idle", {busy4, done4, aborted4, bus_req4}, 4'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
